dadda_mul16_seq: RTL and testbench

Sequential controller that computes a 16x16 unsigned product by time-sharing one `DADDA_8x8_42` instance across four byte-level partial products. It accumulates the partial products into a 32-bit register. Operands enter and results leave through valid/ready handshakes. The block sits between a requester and the shared 8x8 Dadda datapath, for cases where area matters more than throughput.

---
 rtl/dadda_mul16_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_dadda_mul16_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mul16_seq.sv
// dadda_mul16_seq: sequential 16x16 unsigned multiplier that time-shares one
// 8x8 Dadda-style multiplier (DADDA_8x8_42) over four byte partial products.
// Results accumulate in a 32-bit register. Operands enter and results leave
// through valid/ready handshakes.
//
// Optional feature macro: DADDA_SEQ_ZSKIP_EN
//   When defined, steps whose selected a-byte or b-byte is zero are skipped.
//   Latency becomes max(1, number of useful steps). Results are unchanged.
//   When undefined, all four steps always run and latency is fixed at 4.

// 8x8 unsigned multiplier. The eight partial-product rows are reduced by a
// two-level tree of 4:2 compressors, followed by one carry-propagate adder.
// The block is purely combinational.
module DADDA_8x8_42 (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);

    typedef struct packed {
        logic [15:0] s;
        logic [15:0] c;
    } sc_t;

    // 4:2 compressor applied bit-wise across four 16-bit rows. The inner
    // carry (co) depends only on x1..x3, so it does not ripple. All sums are
    // kept modulo 2^16; the real product never exceeds 16 bits, so any bits
    // dropped off the top do not affect the result.
    function automatic sc_t comp42(input logic [15:0] x1, input logic [15:0] x2,
                                   input logic [15:0] x3, input logic [15:0] x4);
        logic [15:0] s1;
        logic [15:0] co;
        logic [15:0] cin;
        logic [15:0] cy;
        sc_t         r;
        s1  = x1 ^ x2 ^ x3;
        co  = (x1 & x2) | (x1 & x3) | (x2 & x3);
        cin = {co[14:0], 1'b0};
        r.s = s1 ^ x4 ^ cin;
        cy  = (s1 & x4) | (s1 & cin) | (x4 & cin);
        r.c = {cy[14:0], 1'b0};
        return r;
    endfunction

    logic [15:0] pp [8];
    sc_t         st0;
    sc_t         st1;
    sc_t         st2;

    // Partial-product generation and the two compressor levels
    always_comb begin
        // NOTE: every variable written here is fully assigned on every pass,
        // so no latch is inferred.
        for (int i = 0; i < 8; i++) begin
            pp[i] = {8'b0, a_i & {8{b_i[i]}}} << i;
        end
        st0 = comp42(pp[0], pp[1], pp[2], pp[3]);
        st1 = comp42(pp[4], pp[5], pp[6], pp[7]);
        st2 = comp42(st0.s, st0.c, st1.s, st1.c);
    end

    assign p_o = st2.s + st2.c;

endmodule

module dadda_mul16_seq #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_prod,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [1:0]        k_q;
    logic [15:0]       a_q;
    logic [15:0]       b_q;
    logic [TAG_W-1:0]  tag_q;
    logic [31:0]       acc_q;
    logic [31:0]       out_prod_q;
    logic [TAG_W-1:0]  out_tag_q;
    logic              out_valid_q;

    logic              accept;
    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic [15:0]       pp16;
    logic [31:0]       term;
    logic [31:0]       acc_d;
    logic [1:0]        k_d;
    logic [1:0]        k_start;
    logic              step_en;
    logic              last_step;

`ifdef DADDA_SEQ_ZSKIP_EN
    logic [3:0]        mask_q;
    logic [3:0]        mask_rem;
    logic [3:0]        mask_start;

    // Index of the lowest set bit; zero when the mask is empty.
    function automatic logic [1:0] penc(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Bit k is set when both bytes selected by step k are nonzero.
    assign mask_start = {(|in_a[15:8]) & (|in_b[15:8]),
                         (|in_a[15:8]) & (|in_b[7:0]),
                         (|in_a[7:0])  & (|in_b[15:8]),
                         (|in_a[7:0])  & (|in_b[7:0])};
    assign k_start    = penc(mask_start);
`else
    assign k_start    = 2'd0;
`endif

    assign in_ready = ~rst & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    assign accept   = in_valid & in_ready;
    assign busy     = (state_q == S_MUL);
    assign out_valid = out_valid_q;
    assign out_prod  = out_prod_q;
    assign out_tag   = out_tag_q;

    // k[1] picks the a-byte, k[0] picks the b-byte.
    assign mul_a = k_q[1] ? a_q[15:8] : a_q[7:0];
    assign mul_b = k_q[0] ? b_q[15:8] : b_q[7:0];

    DADDA_8x8_42 u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (pp16)
    );

    // Align the current partial product to its weight and choose the next step
    always_comb begin
        unique case (k_q)
            2'd0:    term = {16'b0, pp16};
            2'd1,
            2'd2:    term = {8'b0, pp16, 8'b0};
            default: term = {pp16, 16'b0};
        endcase
`ifdef DADDA_SEQ_ZSKIP_EN
        step_en   = |mask_q;
        mask_rem  = mask_q & ~(4'b0001 << k_q);
        last_step = (mask_rem == 4'b0000);
        k_d       = penc(mask_rem);
`else
        step_en   = 1'b1;
        last_step = (k_q == 2'd3);
        k_d       = k_q + 2'd1;
`endif
        acc_d = step_en ? (acc_q + term) : acc_q;
    end

    // Control FSM with its datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= 2'd0;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            acc_q       <= '0;
            out_prod_q  <= '0;
            out_tag_q   <= '0;
            out_valid_q <= 1'b0;
`ifdef DADDA_SEQ_ZSKIP_EN
            mask_q      <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                end
                S_MUL: begin
                    acc_q <= acc_d;
                    if (last_step) begin
                        out_prod_q  <= acc_d;
                        out_tag_q   <= tag_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        k_q <= k_d;
                    end
`ifdef DADDA_SEQ_ZSKIP_EN
                    mask_q <= mask_rem;
`endif
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // Accept is only possible in IDLE or DONE; it overrides the
            // IDLE return above when a new operation arrives on a handshake.
            if (accept) begin
                a_q     <= in_a;
                b_q     <= in_b;
                tag_q   <= in_tag;
                acc_q   <= '0;
                k_q     <= k_start;
                state_q <= S_MUL;
`ifdef DADDA_SEQ_ZSKIP_EN
                mask_q  <= mask_start;
`endif
            end
        end
    end

endmodule

// File: tb/tb_dadda_mul16_seq.sv
// Directed testbench for dadda_mul16_seq. Expected products, tags and
// latencies are hand-computed constants; zero-skip latencies follow the
// DADDA_SEQ_ZSKIP_EN macro.
module tb_dadda_mul16_seq;

    localparam int TAG_W = 4;
`ifdef DADDA_SEQ_ZSKIP_EN
    localparam int ZL = 1;
`else
    localparam int ZL = 4;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_prod;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int vectors;
    int miscompares;

    dadda_mul16_seq #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one operand pair and hold it until the accepting edge has passed.
    // Returns 1 ns after the accept edge (first MUL cycle).
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [TAG_W-1:0] tag);
        int n;
        n = 0;
        in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid is seen, bounded at 40.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, busy, in_ready} !== 3'b000) begin
            $display("FAIL reset_ctrl: got valid/busy/ready=%b want 000", {out_valid, busy, in_ready});
            miscompares++;
        end
        vectors++;
        if (out_prod !== 32'h0 || out_tag !== 4'h0) begin
            $display("FAIL reset_data: got prod=%h tag=%h want 0/0", out_prod, out_tag);
            miscompares++;
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL idle_ready: got %b want 1", in_ready);
            miscompares++;
        end
    endtask

    task automatic test_basic;
        int lat;
        out_ready = 1'b1;
        issue(16'h1234, 16'h5678, 4'h3);
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            $display("FAIL basic_busy: got busy=%b ready=%b want 1/0", busy, in_ready);
            miscompares++;
        end
        wait_valid(lat);
        vectors++;
        if (lat !== 4) begin
            $display("FAIL basic_latency: got %0d want 4", lat);
            miscompares++;
        end
        vectors++;
        if (out_prod !== 32'h06260060 || out_tag !== 4'h3) begin
            $display("FAIL basic_result: got prod=%h tag=%h want 06260060/3", out_prod, out_tag);
            miscompares++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            $display("FAIL basic_busy_done: got %b want 0", busy);
            miscompares++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall;
        int lat;
        out_ready = 1'b0;
        issue(16'hFFFF, 16'hFFFF, 4'h5);
        wait_valid(lat);
        vectors++;
        if (lat !== 4 || out_prod !== 32'hFFFE0001 || out_tag !== 4'h5) begin
            $display("FAIL stall_result: got lat=%0d prod=%h tag=%h want 4/fffe0001/5", lat, out_prod, out_tag);
            miscompares++;
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || out_prod !== 32'hFFFE0001 || out_tag !== 4'h5 || in_ready !== 1'b0) begin
                $display("FAIL stall_hold%0d: got valid=%b prod=%h tag=%h ready=%b want 1/fffe0001/5/0",
                         i, out_valid, out_prod, out_tag, in_ready);
                miscompares++;
            end
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL stall_ready_comb: got %b want 1", in_ready);
            miscompares++;
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("FAIL stall_pop: got valid=%b want 0", out_valid);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        out_ready = 1'b1;
        in_a = 16'h0002; in_b = 16'h0003; in_tag = 4'h1; in_valid = 1'b1;
        @(posedge clk); #1;
        // operands changed during MUL must be ignored; held valid for the next accept
        in_a = 16'h0100; in_b = 16'h0100; in_tag = 4'h2;
        wait_valid(lat);
        vectors++;
        if (lat !== 4 || out_prod !== 32'h00000006 || out_tag !== 4'h1 || in_ready !== 1'b1) begin
            $display("FAIL b2b_first: got lat=%0d prod=%h tag=%h ready=%b want 4/00000006/1/1",
                     lat, out_prod, out_tag, in_ready);
            miscompares++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL b2b_handover: got valid=%b busy=%b want 0/1", out_valid, busy);
            miscompares++;
        end
        wait_valid(lat);
        vectors++;
        if (lat !== 4 || out_prod !== 32'h00010000 || out_tag !== 4'h2) begin
            $display("FAIL b2b_second: got lat=%0d prod=%h tag=%h want 4/00010000/2", lat, out_prod, out_tag);
            miscompares++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort;
        int lat;
        out_ready = 1'b1;
        issue(16'hABCD, 16'h1111, 4'h9);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        vectors++;
        if ({out_valid, busy, in_ready} !== 3'b000 || out_prod !== 32'h0 || out_tag !== 4'h0) begin
            $display("FAIL abort_outputs: got valid/busy/ready=%b prod=%h tag=%h want 000/0/0",
                     {out_valid, busy, in_ready}, out_prod, out_tag);
            miscompares++;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_prod !== 32'h0) begin
            $display("FAIL abort_no_result: got valid=%b prod=%h want 0/0", out_valid, out_prod);
            miscompares++;
        end
        issue(16'h0001, 16'h0001, 4'h7);
        wait_valid(lat);
        vectors++;
        if (lat !== 4 || out_prod !== 32'h00000001 || out_tag !== 4'h7) begin
            $display("FAIL abort_recover: got lat=%0d prod=%h tag=%h want 4/00000001/7", lat, out_prod, out_tag);
            miscompares++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zskip;
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic [31:0] vp [4];
        int          vl [4];
        int          lat;
        va[0] = 16'h00FF; vb[0] = 16'h0003; vp[0] = 32'h000002FD; vl[0] = ZL;
        va[1] = 16'h0100; vb[1] = 16'h0100; vp[1] = 32'h00010000; vl[1] = ZL;
        va[2] = 16'h0000; vb[2] = 16'h1234; vp[2] = 32'h00000000; vl[2] = ZL;
        va[3] = 16'h1234; vb[3] = 16'h5678; vp[3] = 32'h06260060; vl[3] = 4;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i], 4'(i + 10));
            wait_valid(lat);
            vectors++;
            if (lat !== vl[i] || out_prod !== vp[i] || out_tag !== 4'(i + 10)) begin
                $display("FAIL zskip%0d: got lat=%0d prod=%h tag=%h want %0d/%h/%h",
                         i, lat, out_prod, out_tag, vl[i], vp[i], 4'(i + 10));
                miscompares++;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset;
        test_basic;
        test_stall;
        test_back_to_back;
        test_reset_abort;
        test_zskip;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
